seg_display_arbiter: RTL

Time-shares the single 8-digit seven-segment display path among up to NUM_REQ requesters, each offering a 32-bit hex word. Sits directly upstream of the 32-bit multiplexed display driver. It grants one requester at a time using round-robin order, enforces a minimum on-screen dwell time before a switch, and presents the winner's word plus a valid flag to the driver.

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_rr_pick.sv | 35 +++
 rtl/seg_display_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Optional urgent-requester mode is selected by the SEG_ARB_PRIO_EN macro.
package seg_pkg;
   localparam int SEG_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      HOLD  = 2'd2
   } seg_arb_state_t;
endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: lowest requester index at or after
// (ptr_i+1) mod NUM_REQ, wrapping, among the active bits of req_i.
module seg_rr_pick
   import seg_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [IW-1:0]      idx_o,
   output logic               any_o
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [2*NUM_REQ-1:0] w_shift;
   logic [NUM_REQ-1:0]   w_rot;

   // w_rot[j] is the request of requester (ptr+1+j) mod NUM_REQ
   assign w_dbl   = {req_i, req_i};
   assign w_shift = w_dbl >> (int'(ptr_i) + 1);
   assign w_rot   = w_shift[NUM_REQ-1:0];

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            idx_o = IW'((int'(ptr_i) + 1 + j) % NUM_REQ);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin display arbiter with minimum dwell time in front of the 8-digit driver.
// Define SEG_ARB_PRIO_EN to make requester 0 an urgent, preempting requester.
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter  int NUM_REQ      = 4,
   parameter  int DWELL_CYCLES = 50_000_000,
   localparam int OW           = $clog2(NUM_REQ),
   localparam int CW           = $clog2(DWELL_CYCLES + 1)
) (
   input  logic                          clk,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [SEG_WORD_W*NUM_REQ-1:0] data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [OW-1:0]                 owner_o,
   output logic                          valid_o,
   output logic [SEG_WORD_W-1:0]         data_o
);

   seg_arb_state_t        r_state;
   logic [CW-1:0]         r_cnt;
   logic [OW-1:0]         r_ptr;
   logic [OW-1:0]         r_owner;
   logic [NUM_REQ-1:0]    r_gnt;
   logic                  r_valid;
   logic [SEG_WORD_W-1:0] r_data;
`ifdef SEG_ARB_PRIO_EN
   logic                  r_prio;
   logic                  r_req0;
`endif

   logic [SEG_WORD_W-1:0] w_words [NUM_REQ];
   logic [NUM_REQ-1:0]    w_pick_req;
   logic [OW-1:0]         w_pick_idx;
   logic                  w_pick_any;
   logic                  w_owner_req;
   logic                  w_dwell_done;
   logic                  w_take;
   logic                  w_go_idle;
   logic                  w_go_hold;
   logic                  w_urgent;
   logic [OW-1:0]         w_own_nxt;
   logic                  w_vld_nxt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_words
         assign w_words[gi] = data_i[gi*SEG_WORD_W +: SEG_WORD_W];
      end
   endgenerate

   // Once owned, the current owner is masked so a switch always lands elsewhere
   assign w_pick_req   = (r_state == IDLE) ? req_i : (req_i & ~r_gnt);
   assign w_owner_req  = r_valid & req_i[r_owner];
   assign w_dwell_done = (int'(r_cnt) + 2 >= DWELL_CYCLES);

   seg_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (OW)
   ) u_pick (
      .req_i (w_pick_req),
      .ptr_i (r_ptr),
      .idx_o (w_pick_idx),
      .any_o (w_pick_any)
   );

   always_comb begin
      w_take    = 1'b0;
      w_go_idle = 1'b0;
      w_go_hold = 1'b0;
      w_urgent  = 1'b0;
`ifdef SEG_ARB_PRIO_EN
      if (req_i[0] && !r_req0 && !(r_valid && r_owner == '0)) begin
         w_urgent = 1'b1;
      end else if (r_prio) begin
         if (!req_i[0]) begin
            w_take    = w_pick_any;
            w_go_idle = !w_pick_any;
         end
      end else
`endif
      begin
         case (r_state)
            IDLE: w_take = w_pick_any;
            DWELL: begin
               // An owner drop wins over a simultaneous dwell expiry
               if (!w_owner_req) begin
                  w_take    = w_pick_any;
                  w_go_idle = !w_pick_any;
               end else if (w_dwell_done) begin
                  w_go_hold = 1'b1;
               end
            end
            HOLD: begin
               if (w_pick_any) begin
                  w_take = 1'b1;
               end else if (!w_owner_req) begin
                  w_go_idle = 1'b1;
               end
            end
            default: w_go_idle = 1'b1;
         endcase
      end
   end

   always_comb begin
      w_own_nxt = r_owner;
      w_vld_nxt = r_valid;
      if (w_urgent) begin
         w_own_nxt = '0;
         w_vld_nxt = 1'b1;
      end else if (w_take) begin
         w_own_nxt = w_pick_idx;
         w_vld_nxt = 1'b1;
      end else if (w_go_idle) begin
         w_own_nxt = '0;
         w_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
`ifdef SEG_ARB_PRIO_EN
         r_prio  <= 1'b0;
         r_req0  <= 1'b0;
`endif
      end else begin
         r_owner <= w_own_nxt;
         r_valid <= w_vld_nxt;
         r_gnt   <= w_vld_nxt ? (NUM_REQ'(1) << w_own_nxt) : '0;
         r_data  <= w_vld_nxt ? w_words[w_own_nxt] : '0;
`ifdef SEG_ARB_PRIO_EN
         r_req0  <= req_i[0];
         if (w_urgent) begin
            r_prio <= 1'b1;
         end else if (w_take || w_go_idle) begin
            r_prio <= 1'b0;
         end
`endif
         if (w_urgent) begin
            // Preemption leaves r_ptr alone so rotation resumes where it stopped
            r_state <= HOLD;
            r_cnt   <= '0;
         end else if (w_take) begin
            r_state <= DWELL;
            r_cnt   <= '0;
            r_ptr   <= w_pick_idx;
         end else if (w_go_idle) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            if (w_go_hold) begin
               r_state <= HOLD;
            end
            if (r_state != IDLE && int'(r_cnt) < DWELL_CYCLES) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign gnt_o   = r_gnt;
   assign owner_o = r_owner;
   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule
